ag32gbd_reg_responder: RTL and testbench
========================================

// Module: ag32gbd_reg_responder
// PURPOSE
// Responder side of the sampler's register-read handshake (RequestReadReg/RegReadAddr ->
// RegReadOutput/RegReadDone). Serves 8-bit reads from the camera register/dither-threshold
// BRAM (thresholds at 10'h200 + 3*pixel + {0,1,2}). Arbitrates the single BRAM port against
// host register writes; writes have priority. Four-phase level handshake; one read in flight.
// PARAMETERS
// READ_LATENCY  1     BRAM clocks from address sample to valid BramRdData (legal 1..3)
// DEPTH         1024  implemented words; addresses >= DEPTH read 8'h00, BRAM untouched
// PORTS
// sys_clock       in   1   system clock (100MHz)
// sys_reset       in   1   synchronous reset, active high
// RequestReadReg  in   1   read request level from initiator
// RegReadAddr     in   10  read address, valid while RequestReadReg high
// RegReadOutput   out  8   read data, valid while RegReadDone high
// RegReadDone     out  1   read complete, level, held until request observed low
// HostWrEn        in   1   host register write strobe, one cycle per write
// HostWrAddr      in   10  host write address
// HostWrData      in   8   host write data
// BramAddr        out  10  BRAM address
// BramWrEn        out  1   BRAM write enable
// BramWrData      out  8   BRAM write data
// BramRdData      in   8   BRAM read data, READ_LATENCY clocks after address sampled
// BEHAVIOUR
// - Reset (sync, one edge): RegReadDone=0, RegReadOutput=8'h00, BramWrEn=0, BramAddr=0,
//   BramWrData=0, state IDLE, latency counter 0. Reset mid-read: read discarded, no Done.
// - Host write: HostWrEn=1 drives BramAddr/BramWrData/BramWrEn combinationally that same
//   cycle, in any state. Never stalled, never dropped.
// - FSM states: IDLE, ISSUE, WAIT, DONE.
// - IDLE: RequestReadReg=1 and RegReadDone=0 -> latch RegReadAddr into rd_addr, go to ISSUE.
// - ISSUE: BramAddr=rd_addr.
//   - HostWrEn=1: BRAM port taken by the write; stay in ISSUE.
//   - Otherwise: address sampled; load counter with READ_LATENCY-1; go to WAIT.
//   - rd_addr >= DEPTH: no BRAM access; data forced to 8'h00; same timing as a real read.
// - WAIT: decrement counter each clock. At count 0, capture BramRdData (or 8'h00) into
//   RegReadOutput, set RegReadDone=1, go to DONE.
//   - With READ_LATENCY=1 and no write conflict, Done rises at the 2nd edge after the edge
//     that latched the request. General latency: 1+READ_LATENCY edges, +1 per stalled cycle.
// - Write forwarding: HostWrEn=1 with HostWrAddr==rd_addr while in WAIT, or in the
//   capture cycle, makes the captured data HostWrData (newest write wins), never stale data.
// - DONE: hold RegReadDone=1 and RegReadOutput stable. RequestReadReg sampled low ->
//   RegReadDone=0 next edge, go to IDLE. A one-cycle low pulse on the request suffices.
// - Abort: RequestReadReg low in ISSUE or WAIT -> go to IDLE, no Done. RegReadOutput keeps
//   its previous value; any BRAM data still in flight is ignored.
// - The next read is accepted only from IDLE with RegReadDone=0. A request held high
//   through DONE->IDLE is a new read, latched at the first IDLE edge.
// - RegReadOutput changes only at capture or reset.
// STRUCTURE
// - ag32gbd_pkg: FSM state localparams (one-hot, 4 bits); DITHER_BASE=10'h200;
//   DITHER_WORDS=48; REG_WORDS=54; ADDR_W=10; DATA_W=8.
// - One sub-module: ag32gbd_lat_counter (loadable 2-bit down counter, zero flag).
//   Arbitration, forwarding and FSM stay in this file.
// TESTING
// 1 Reset, then a read: RequestReadReg=1, RegReadAddr=10'h203, BRAM[203]=8'h5A ->
//   RegReadDone rises 2 edges after latch, RegReadOutput=8'h5A.
// 2 Handshake: drop the request for 1 cycle after Done, re-raise with 10'h204 (8'h80) ->
//   Done falls 1 edge later; second Done carries 8'h80; no double accept.
// 3 Write conflict: HostWrEn=1 for 3 cycles during ISSUE ->
//   Done delayed by exactly 3 cycles; all 3 writes land in BRAM.
// 4 Forwarding: read 10'h210 (BRAM 8'h11), write 10'h210=8'hC3 in WAIT (READ_LATENCY=3) ->
//   RegReadOutput=8'hC3.
// 5 Abort and out-of-range: request dropped in WAIT -> no Done, output unchanged.
//   DEPTH=560, read 10'h3FF -> Done with 8'h00, BramWrEn=0.
// 6 Reset mid-read (asserted in WAIT) -> all outputs at reset values next edge;
//   the next read completes normally.

Source files
------------

// File: rtl/ag32gbd_pkg.sv
// Shared constants and FSM encoding for the sampler register-read responder.
// Address map: camera registers at the bottom, dither thresholds from DITHER_BASE.
package ag32gbd_pkg;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 8;
    localparam int DITHER_WORDS = 48;
    localparam int REG_WORDS    = 54;
    localparam logic [ADDR_W-1:0] DITHER_BASE = 10'h200;

    localparam logic [3:0] ST_IDLE_OH  = 4'b0001;
    localparam logic [3:0] ST_ISSUE_OH = 4'b0010;
    localparam logic [3:0] ST_WAIT_OH  = 4'b0100;
    localparam logic [3:0] ST_DONE_OH  = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE  = ST_IDLE_OH,
        ST_ISSUE = ST_ISSUE_OH,
        ST_WAIT  = ST_WAIT_OH,
        ST_DONE  = ST_DONE_OH
    } state_t;

endpackage

// File: rtl/ag32gbd_lat_counter.sv
// Loadable 2-bit down counter that tracks outstanding BRAM read latency.
// Saturates at zero; zero flag marks the capture cycle.
module ag32gbd_lat_counter (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 2'd0)) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 2'd0);

endmodule

// File: rtl/ag32gbd_reg_responder.sv
// Responder for the register-read handshake: shares one BRAM port with host writes
// (writes always win), forwards late writes to the read address, four-phase Done.
module ag32gbd_reg_responder
    import ag32gbd_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int DEPTH        = 1024
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              RequestReadReg,
    input  logic [ADDR_W-1:0] RegReadAddr,
    output logic [DATA_W-1:0] RegReadOutput,
    output logic              RegReadDone,
    input  logic              HostWrEn,
    input  logic [ADDR_W-1:0] HostWrAddr,
    input  logic [DATA_W-1:0] HostWrData,
    output logic [ADDR_W-1:0] BramAddr,
    output logic              BramWrEn,
    output logic [DATA_W-1:0] BramWrData,
    input  logic [DATA_W-1:0] BramRdData
);

    localparam logic [1:0]  LAT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              done_q, done_d;
    logic              fwd_vld_q, fwd_vld_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              rd_oor, wr_hit;
    logic [DATA_W-1:0] cap_data;

    ag32gbd_lat_counter u_lat_counter (
        .clk      (sys_clock),
        .srst     (sys_reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign rd_oor = (32'(rd_addr_q) >= DEPTH_U);
    assign wr_hit = HostWrEn && (HostWrAddr == rd_addr_q);

    // Newest source wins: a write in the capture cycle beats one seen earlier in WAIT.
    always_comb begin
        if (rd_oor) begin
            cap_data = '0;
        end else if (wr_hit) begin
            cap_data = HostWrData;
        end else if (fwd_vld_q) begin
            cap_data = fwd_data_q;
        end else begin
            cap_data = BramRdData;
        end
    end

    always_comb begin
        BramAddr   = rd_addr_q;
        BramWrEn   = 1'b0;
        BramWrData = '0;
        if (HostWrEn) begin
            BramAddr   = HostWrAddr;
            BramWrEn   = 1'b1;
            BramWrData = HostWrData;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        out_d      = out_q;
        done_d     = done_q;
        fwd_vld_d  = fwd_vld_q;
        fwd_data_d = fwd_data_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RequestReadReg && !done_q) begin
                    rd_addr_d = RegReadAddr;
                    fwd_vld_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!RequestReadReg) begin
                    state_d = ST_IDLE;
                end else if (!HostWrEn) begin
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!RequestReadReg) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    out_d   = cap_data;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                    if (wr_hit) begin
                        fwd_vld_d  = 1'b1;
                        fwd_data_d = HostWrData;
                    end
                end
            end
            ST_DONE: begin
                if (!RequestReadReg) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            out_q      <= out_d;
            done_q     <= done_d;
            fwd_vld_q  <= fwd_vld_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign RegReadOutput = out_q;
    assign RegReadDone   = done_q;

endmodule

// File: tb/tb_ag32gbd_reg_responder.sv
// Bench for the register-read responder: two instances (latency 1 / depth 1024 and
// latency 3 / depth 560) share stimulus; reference is a flat "latest written value" memory.
module tb_ag32gbd_reg_responder;

    logic       clk = 1'b0;
    logic       rst, req, wen;
    logic [9:0] raddr, waddr;
    logic [7:0] wdata;

    logic [7:0] o1_out, o3_out, b1_wd, b3_wd, rd1, rd3;
    logic       o1_done, o3_done, b1_we, b3_we;
    logic [9:0] b1_addr, b3_addr;

    logic [7:0] mem1 [1024];
    logic [7:0] mem3 [1024];
    logic [7:0] p3 [3];
    logic [7:0] ref_mem [1024];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ag32gbd_reg_responder #(.READ_LATENCY(1), .DEPTH(1024)) dut1 (
        .sys_clock(clk), .sys_reset(rst), .RequestReadReg(req), .RegReadAddr(raddr),
        .RegReadOutput(o1_out), .RegReadDone(o1_done), .HostWrEn(wen), .HostWrAddr(waddr),
        .HostWrData(wdata), .BramAddr(b1_addr), .BramWrEn(b1_we), .BramWrData(b1_wd),
        .BramRdData(rd1)
    );

    ag32gbd_reg_responder #(.READ_LATENCY(3), .DEPTH(560)) dut3 (
        .sys_clock(clk), .sys_reset(rst), .RequestReadReg(req), .RegReadAddr(raddr),
        .RegReadOutput(o3_out), .RegReadDone(o3_done), .HostWrEn(wen), .HostWrAddr(waddr),
        .HostWrData(wdata), .BramAddr(b3_addr), .BramWrEn(b3_we), .BramWrData(b3_wd),
        .BramRdData(rd3)
    );

    always @(posedge clk) begin
        if (b1_we) mem1[b1_addr] <= b1_wd;
        rd1 <= mem1[b1_addr];
    end

    always @(posedge clk) begin
        if (b3_we) mem3[b3_addr] <= b3_wd;
        p3[0] <= mem3[b3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    function automatic logic get_done(input int inst);
        return (inst == 1) ? o1_done : o3_done;
    endfunction

    function automatic logic [7:0] get_out(input int inst);
        return (inst == 1) ? o1_out : o3_out;
    endfunction

    function automatic logic get_we(input int inst);
        return (inst == 1) ? b1_we : b3_we;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [9:0] a, input logic [7:0] d);
        wen = 1'b1;
        waddr = a;
        wdata = d;
        ref_mem[a] = d;
    endtask

    // Read of addr on instance inst: s stalling writes, optional forward write at cycle fwd_k,
    // optional random writes while waiting. Expect Done after 1+L+s edges with latest data.
    task automatic run_read(input int inst, input logic [9:0] addr, input int s, input bit rnd,
                            input int fwd_k, input logic [7:0] fwd_val, input string name);
        int lat, edges;
        bit got, bad_we;
        logic [7:0] exp_d;
        lat = (inst == 1) ? 1 : 3;
        got = 0;
        bad_we = 0;
        edges = 0;
        req = 1'b1;
        raddr = addr;
        step();
        for (int k = 0; k < 40 && !got; k++) begin
            if (k < s) begin
                host_wr(rnd ? 10'($urandom_range(0, 1023)) : (10'h100 + 10'(k)), 8'($urandom));
            end else if (k == fwd_k) begin
                host_wr(addr, fwd_val);
            end else if (k > s && rnd && $urandom_range(0, 2) == 0) begin
                host_wr(($urandom_range(0, 3) == 0) ? addr : 10'($urandom_range(0, 1023)),
                        8'($urandom));
            end else begin
                wen = 1'b0;
            end
            step();
            edges = k + 1;
            if (!wen && get_we(inst)) bad_we = 1;
            if (get_done(inst)) got = 1;
        end
        wen = 1'b0;
        exp_d = (inst == 3 && addr >= 10'd560) ? 8'h00 : ref_mem[addr];
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: inst=%0d addr=%h Done not seen within %0d edges", name, inst, addr, edges);
        end
        checks++;
        if (edges !== 1 + lat + s) begin
            failures++;
            $display("FAIL %s_latency: inst=%0d got %0d edges, required %0d", name, inst, edges, 1 + lat + s);
        end
        checks++;
        if (get_out(inst) !== exp_d) begin
            failures++;
            $display("FAIL %s_data: inst=%0d addr=%h got %h, required %h", name, inst, addr, get_out(inst), exp_d);
        end
        checks++;
        if (bad_we) begin
            failures++;
            $display("FAIL %s_bram_we: inst=%0d BramWrEn high without host write, required 0", name, inst);
        end
        $display("read %s inst=%0d addr=%h stalls=%0d edges=%0d data=%h exp=%h", name, inst, addr, s, edges, get_out(inst), exp_d);
    endtask

    task automatic finish_read(input int inst, input string name);
        req = 1'b0;
        wen = 1'b0;
        step();
        checks++;
        if (get_done(inst) !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_fall: inst=%0d got %b, required 0", name, inst, get_done(inst));
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        wen = 1'b0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        step();
        step();
        checks++;
        if ({o1_done, o1_out, b1_addr, b1_we, b1_wd} !== 28'd0 ||
            {o3_done, o3_out, b3_addr, b3_we, b3_wd} !== 28'd0) begin
            failures++;
            $display("FAIL reset_state: got %b%h%h%b%h / %b%h%h%b%h, required all zero",
                     o1_done, o1_out, b1_addr, b1_we, b1_wd, o3_done, o3_out, b3_addr, b3_we, b3_wd);
        end
        $display("reset outputs done=%b/%b out=%h/%h", o1_done, o3_done, o1_out, o3_out);
        rst = 1'b0;
        step();
    endtask

    task automatic preload();
        logic [7:0] v;
        for (int a = 0; a < 1024; a++) begin
            v = 8'($urandom);
            case (a)
                'h203: v = 8'h5A;
                'h204: v = 8'h80;
                'h210: v = 8'h11;
                'h220: v = 8'h3C;
                'h3FF: v = 8'hA5;
                default: ;
            endcase
            host_wr(10'(a), v);
            step();
        end
        wen = 1'b0;
        step();
    endtask

    task automatic test_basic_read();
        run_read(1, 10'h203, 0, 0, -1, 8'h00, "t1");
        checks++;
        if (o1_out !== 8'h5A) begin
            failures++;
            $display("FAIL t1_value: got %h, required 5a", o1_out);
        end
    endtask

    task automatic test_handshake();
        req = 1'b0;
        step();
        checks++;
        if (o1_done !== 1'b0) begin
            failures++;
            $display("FAIL t2_fall: got %b, required 0", o1_done);
        end
        run_read(1, 10'h204, 0, 0, -1, 8'h00, "t2");
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o1_done !== 1'b1 || o1_out !== 8'h80) begin
                failures++;
                $display("FAIL t2_hold: cycle %0d got done=%b out=%h, required 1 80", i, o1_done, o1_out);
            end
        end
        finish_read(1, "t2");
    endtask

    task automatic test_write_conflict();
        run_read(1, 10'h205, 3, 0, -1, 8'h00, "t3");
        finish_read(1, "t3");
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem1[10'h100 + 10'(k)] !== ref_mem[10'h100 + 10'(k)]) begin
                failures++;
                $display("FAIL t3_write_landed: addr %h got %h, required %h", 10'h100 + 10'(k),
                         mem1[10'h100 + 10'(k)], ref_mem[10'h100 + 10'(k)]);
            end
        end
    endtask

    task automatic test_forwarding();
        run_read(3, 10'h210, 0, 0, 1, 8'hC3, "t4");
        checks++;
        if (o3_out !== 8'hC3) begin
            failures++;
            $display("FAIL t4_forward: got %h, required c3", o3_out);
        end
        finish_read(3, "t4");
    endtask

    task automatic test_abort_oor();
        logic [7:0] prev;
        prev = o3_out;
        req = 1'b1;
        raddr = 10'h220;
        step();
        step();
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (o3_done !== 1'b0 || o3_out !== prev) begin
                failures++;
                $display("FAIL t5_abort: cycle %0d got done=%b out=%h, required 0 %h", i, o3_done, o3_out, prev);
            end
        end
        $display("abort inst=3 addr=220 out=%h", o3_out);
        run_read(3, 10'h3FF, 0, 0, -1, 8'h00, "t5_oor");
        checks++;
        if (o3_out !== 8'h00) begin
            failures++;
            $display("FAIL t5_oor_zero: got %h, required 00", o3_out);
        end
        finish_read(3, "t5_oor");
    endtask

    task automatic test_reset_mid_read();
        req = 1'b1;
        raddr = 10'h230;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({o3_done, o3_out, b3_addr, b3_we, b3_wd} !== 28'd0) begin
            failures++;
            $display("FAIL t6_reset: got done=%b out=%h addr=%h we=%b wd=%h, required all zero",
                     o3_done, o3_out, b3_addr, b3_we, b3_wd);
        end
        rst = 1'b0;
        req = 1'b0;
        step();
        step();
        checks++;
        if (o3_done !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_done: got %b, required 0", o3_done);
        end
        run_read(3, 10'h230, 0, 0, -1, 8'h00, "t6");
        finish_read(3, "t6");
    endtask

    task automatic test_random();
        int inst, s, lat, fk;
        logic [9:0] a;
        for (int it = 0; it < 24; it++) begin
            inst = ($urandom_range(0, 1) == 0) ? 1 : 3;
            lat = (inst == 1) ? 1 : 3;
            a = 10'($urandom_range(0, 1023));
            s = $urandom_range(0, 3);
            fk = ($urandom_range(0, 1) == 0) ? -1 : (s + 1 + $urandom_range(0, lat - 1));
            run_read(inst, a, s, 1, fk, 8'($urandom), $sformatf("rnd%0d", it));
            finish_read(inst, $sformatf("rnd%0d", it));
        end
    endtask

    task automatic test_bram_contents();
        int bad1, bad3;
        bad1 = 0;
        bad3 = 0;
        for (int a = 0; a < 1024; a++) begin
            if (mem1[a] !== ref_mem[a]) bad1++;
            if (mem3[a] !== ref_mem[a]) bad3++;
        end
        checks++;
        if (bad1 != 0 || bad3 != 0) begin
            failures++;
            $display("FAIL bram_contents: got %0d/%0d differing words, required 0/0", bad1, bad3);
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_read();
        test_handshake();
        test_write_conflict();
        test_forwarding();
        test_abort_oor();
        test_reset_mid_read();
        test_random();
        test_bram_contents();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
